// File: rtl/display_scan_controller.sv
// display_scan_controller: four-digit 7-segment scan sequencer with per-digit dimming.
// Define SCAN_BLANKING_EN to add a BLANK_CYCLES anti-ghosting gap after each digit.
module display_scan_controller #(
    parameter int unsigned PRESCALE     = 8,
    parameter int unsigned BLANK_CYCLES = 3
) (
    input  logic       clk_in,
    input  logic       reset_n_in,
    input  logic       enable_in,
    input  logic [1:0] dim_in,
    output logic [1:0] address,
    output logic [3:0] digit_enable_out,
    output logic       frame_start_out,
    output logic       busy_out
);

    if (PRESCALE < 4 || PRESCALE > 65535 ||
        BLANK_CYCLES < 1 || BLANK_CYCLES > 255) begin : g_bad_cfg
        $error("display_scan_controller: illegal PRESCALE/BLANK_CYCLES");
    end

    localparam logic [15:0] PRE16     = 16'(PRESCALE);
    localparam logic [15:0] SHOW_LAST = 16'(PRESCALE - 1);
`ifdef SCAN_BLANKING_EN
    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
`ifdef SCAN_BLANKING_EN
        S_SHOW   = 2'd2,
        S_BLANK  = 2'd3
`else
        S_SHOW   = 2'd2
`endif
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] on_q;
    logic [15:0] on_shift;
    logic [15:0] on_next;
    logic [3:0]  digit_onehot;

    // A shift that empties the on-time still lights the digit for one cycle.
    always_comb begin
        on_shift     = PRE16 >> dim_in;
        on_next      = (on_shift == 16'd0) ? 16'd1 : on_shift;
        digit_onehot = 4'b0001 << address;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state            <= S_IDLE;
            cnt              <= 16'd0;
            on_q             <= 16'd0;
            address          <= 2'd0;
            digit_enable_out <= 4'd0;
            frame_start_out  <= 1'b0;
            busy_out         <= 1'b0;
        end else if (!enable_in) begin
            state            <= S_IDLE;
            cnt              <= 16'd0;
            on_q             <= 16'd0;
            address          <= 2'd0;
            digit_enable_out <= 4'd0;
            frame_start_out  <= 1'b0;
            busy_out         <= 1'b0;
        end else begin
            frame_start_out <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    state            <= S_SETTLE;
                    cnt              <= 16'd0;
                    address          <= 2'd0;
                    digit_enable_out <= 4'd0;
                    busy_out         <= 1'b1;
                end
                S_SETTLE: begin
                    if (cnt == 16'd1) begin
                        state            <= S_SHOW;
                        cnt              <= 16'd0;
                        on_q             <= on_next;
                        digit_enable_out <= digit_onehot;
                        frame_start_out  <= (address == 2'd0);
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        cnt              <= 16'd0;
                        digit_enable_out <= 4'd0;
`ifdef SCAN_BLANKING_EN
                        state            <= S_BLANK;
`else
                        state            <= S_SETTLE;
                        address          <= address + 2'd1;
`endif
                    end else begin
                        cnt              <= cnt + 16'd1;
                        digit_enable_out <= ((cnt + 16'd1) < on_q) ?
                                            digit_onehot : 4'd0;
                    end
                end
`ifdef SCAN_BLANKING_EN
                S_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state   <= S_SETTLE;
                        cnt     <= 16'd0;
                        address <= address + 2'd1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
